// File: rtl/note_tone_gen.sv
// note_tone_gen
//   Playback stage for the recorder. Turns the replayed one-hot note code into
//   a square wave at the matching C-major pitch (C4..C5) from the 5 MHz clock.
//   Pitch changes and rests are only applied at a waveform edge (terminal
//   count), so the output never carries a truncated half-period.
//
// Ports
//   clk_5MHz   in   system clock, 5 MHz
//   resetn     in   asynchronous, active-low reset
//   play_en    in   1 = accept notes, 0 = force rest
//   note_in    in   [7:0] one-hot note, bit0 = C4 .. bit7 = C5, 0 = rest
//   octave_up  in   (TONE_OCTAVE_EN only) 1 = halve the half-period
//   audio_out  out  square wave
//   playing    out  1 while in PLAY
//   cur_note   out  [2:0] index of the sounding note, 0 when idle
//
// Build option
//   TONE_OCTAVE_EN : adds octave_up; reload becomes table[idx] >> 1 when set.
module note_tone_gen #(
    parameter int CNT_W = 14
) (
    input  logic       clk_5MHz,
    input  logic       resetn,
    input  logic       play_en,
    input  logic [7:0] note_in,
`ifdef TONE_OCTAVE_EN
    input  logic       octave_up,
`endif
    output logic       audio_out,
    output logic       playing,
    output logic [2:0] cur_note
);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               audio_n;
    logic [2:0]         cur_n;
    logic [7:0]         note_q;
    logic [2:0]         pend_idx;
    logic               pend_rest;
    logic [CNT_W-1:0]   half_per;
    logic [CNT_W-1:0]   reload;

    // Half-period in 5 MHz cycles for C4 D4 E4 F4 G4 A4 B4 C5.
    function automatic logic [CNT_W-1:0] half_period(input logic [2:0] idx);
        case (idx)
            3'd0:    half_period = CNT_W'(9555);
            3'd1:    half_period = CNT_W'(8513);
            3'd2:    half_period = CNT_W'(7584);
            3'd3:    half_period = CNT_W'(7159);
            3'd4:    half_period = CNT_W'(6378);
            3'd5:    half_period = CNT_W'(5682);
            3'd6:    half_period = CNT_W'(5062);
            default: half_period = CNT_W'(4778);
        endcase
    endfunction

    // Decode straight from note_q so a note reaches audio_out two edges after
    // it appears on note_in. Lowest set bit wins: scan high to low so the
    // last hit (the lowest bit) sticks.
    always_comb begin
        pend_rest = (note_q == 8'd0);
        pend_idx  = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (note_q[i]) pend_idx = i[2:0];
        end
    end

    always_comb begin
        half_per = half_period(pend_idx);
`ifdef TONE_OCTAVE_EN
        reload = octave_up ? (half_per >> 1) : half_per;
`else
        reload = half_per;
`endif
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        audio_n = audio_out;
        cur_n   = cur_note;
        case (state)
            IDLE: begin
                audio_n = 1'b0;
                cur_n   = 3'd0;
                if (!pend_rest) begin
                    state_n = PLAY;
                    audio_n = 1'b1;
                    // Loaded value counts down to 0 inclusive: table[idx] cycles.
                    cnt_n   = reload - CNT_W'(1);
                    cur_n   = pend_idx;
                end
            end
            PLAY: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else if (pend_rest) begin
                    // Rest lands on a half-period boundary, never mid-pulse.
                    state_n = IDLE;
                    audio_n = 1'b0;
                    cur_n   = 3'd0;
                    cnt_n   = '0;
                end else begin
                    audio_n = ~audio_out;
                    cnt_n   = reload - CNT_W'(1);
                    cur_n   = pend_idx;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_5MHz or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            audio_out <= 1'b0;
            cur_note  <= 3'd0;
            note_q    <= 8'd0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            audio_out <= audio_n;
            cur_note  <= cur_n;
            note_q    <= play_en ? note_in : 8'd0;
        end
    end

    // Decoded from the state register so reset clears it with no clock edge.
    assign playing = (state == PLAY);

endmodule

// File: tb/tb_note_tone_gen.sv
module tb_note_tone_gen;

    localparam int LIMIT = 20000;

    logic       clk = 1'b0;
    logic       resetn;
    logic       play_en;
    logic [7:0] note_in;
`ifdef TONE_OCTAVE_EN
    logic       octave_up = 1'b0;
`endif
    logic       audio_out;
    logic       playing;
    logic [2:0] cur_note;

    int n_tests = 0;
    int n_fail  = 0;
    int n;

    always #100 clk = ~clk;   // 5 MHz

    note_tone_gen dut (
        .clk_5MHz  (clk),
        .resetn    (resetn),
        .play_en   (play_en),
        .note_in   (note_in),
`ifdef TONE_OCTAVE_EN
        .octave_up (octave_up),
`endif
        .audio_out (audio_out),
        .playing   (playing),
        .cur_note  (cur_note)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Hold reset across two clock edges, release on a falling edge.
    task automatic do_reset();
        resetn  = 1'b0;
        play_en = 1'b0;
        note_in = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Falling edges until audio_out is seen high.
    task automatic wait_rise(output int cnt);
        cnt = 0;
        while (cnt < LIMIT) begin
            @(negedge clk);
            cnt++;
            if (audio_out === 1'b1) break;
        end
    endtask

    // Called on the falling edge where a level was first seen; returns how many
    // cycles it lasts and leaves us on the edge where the new level appears.
    task automatic hold_len(input bit use_play, output int cnt);
        logic v;
        v   = use_play ? playing : audio_out;
        cnt = 1;
        while (cnt < LIMIT) begin
            @(negedge clk);
            if ((use_play ? playing : audio_out) !== v) break;
            cnt++;
        end
    endtask

    initial begin
        resetn  = 1'b0;
        play_en = 1'b0;
        note_in = 8'd0;
        #50;
        chk("rst_audio", audio_out, 0);
        chk("rst_playing", playing, 0);
        chk("rst_cur_note", cur_note, 0);

        // A4: onset latency, then steady 5682-cycle halves.
        do_reset();
        play_en = 1'b1;
        note_in = 8'h20;
        wait_rise(n);            chk("a4_onset", n, 2);
        chk("a4_playing", playing, 1);
        chk("a4_cur_note", cur_note, 5);
        hold_len(0, n);          chk("a4_high", n, 5682);
        hold_len(0, n);          chk("a4_low", n, 5682);
        hold_len(0, n);          chk("a4_high2", n, 5682);

        // C4 -> C5 mid half: the 9555 half completes, then 4778 halves.
        do_reset();
        play_en = 1'b1;
        note_in = 8'h01;
        wait_rise(n);            chk("c4_onset", n, 2);
        chk("c4_cur_note", cur_note, 0);
        note_in = 8'h80;
        hold_len(0, n);          chk("c4_high_full", n, 9555);
        chk("c5_cur_note", cur_note, 7);
        hold_len(0, n);          chk("c5_low", n, 4778);
        hold_len(0, n);          chk("c5_high", n, 4778);

        // G4 rest requested during high half: high completes, then idle.
        do_reset();
        play_en = 1'b1;
        note_in = 8'h10;
        wait_rise(n);            chk("g4_onset", n, 2);
        note_in = 8'h00;
        hold_len(0, n);          chk("g4_high_rest", n, 6378);
        chk("g4_rest_playing", playing, 0);
        chk("g4_rest_cur_note", cur_note, 0);
        repeat (20) @(negedge clk);
        chk("g4_rest_audio", audio_out, 0);
        chk("g4_rest_playing2", playing, 0);

        // G4 rest requested during low half: PLAY ends at the low terminal.
        note_in = 8'h10;
        wait_rise(n);            chk("g4b_onset", n, 2);
        hold_len(0, n);          chk("g4b_high", n, 6378);
        note_in = 8'h00;
        hold_len(1, n);          chk("g4b_low_rest", n, 6378);
        chk("g4b_audio", audio_out, 0);
        chk("g4b_cur_note", cur_note, 0);

        // Priority decode 8'hA4 -> E4, then play_en drop acts as a rest.
        do_reset();
        play_en = 1'b1;
        note_in = 8'hA4;
        wait_rise(n);            chk("e4_onset", n, 2);
        chk("e4_cur_note", cur_note, 2);
        hold_len(0, n);          chk("e4_high", n, 7584);
        play_en = 1'b0;
        hold_len(1, n);          chk("e4_pen_rest", n, 7584);
        chk("e4_pen_audio", audio_out, 0);
        play_en = 1'b1;
        wait_rise(n);            chk("e4_restart", n, 2);
        chk("e4_restart_note", cur_note, 2);

        // Asynchronous reset mid-note, three cycles low, restart in 2.
        repeat (50) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("arst_audio", audio_out, 0);
        chk("arst_playing", playing, 0);
        chk("arst_cur_note", cur_note, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        wait_rise(n);            chk("arst_restart", n, 2);
        chk("arst_cur_note2", cur_note, 2);

`ifdef TONE_OCTAVE_EN
        // Octave up on A4: 2841 halves until the reload after octave_up drops.
        do_reset();
        octave_up = 1'b1;
        play_en   = 1'b1;
        note_in   = 8'h20;
        wait_rise(n);            chk("oct_onset", n, 2);
        hold_len(0, n);          chk("oct_high", n, 2841);
        octave_up = 1'b0;
        hold_len(0, n);          chk("oct_low", n, 2841);
        hold_len(0, n);          chk("oct_high_norm", n, 5682);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/note_tone_gen.md
# note_tone_gen

Downstream playback stage for the recorder: takes the 8-bit note code replayed by the record/replay block (one key per bit) and drives a square-wave audio output at the matching C-major pitch, C4..C5, from the 5 MHz system clock. Pitch changes and rests take effect only at a waveform edge, which keeps the output glitch-free. A simple status interface reports what is sounding.

## Interface
- CNT_W, 14: half-period counter width. Must hold 9555, the largest table entry.
- clk_5MHz  input  1  system clock, 5 MHz.
- resetn  input  1  reset, asynchronous, active-low.
- play_en  input  1  1 = accept notes; 0 = treat note_in as rest.
- note_in  input  8  one-hot note code; bit0=C4 … bit7=C5; 0 = rest.
- audio_out  output  1  square wave to the speaker/DAC pin.
- playing  output  1  1 while in PLAY state.
- cur_note  output  3  index of the sounding note (0..7); 0 when idle.
- octave_up  input  1  present only with TONE_OCTAVE_EN; 1 = one octave higher.

## Operation
- Decided: one clock; reset is asynchronous and active-low.
- Input stage: note_q <= play_en ? note_in : 0 every cycle.
- Decode: lowest set bit of note_q wins (e.g. 8'b1010_0000 → index 5). note_q==0 → rest.
- Half-period table (cycles at 5 MHz), indices 0..7: 9555, 8513, 7584, 7159, 6378, 5682, 5062, 4778.
- pend_idx / pend_rest hold the decoded value of note_q, updated every cycle.
- States and transitions:
  - IDLE: audio_out=0, playing=0, cur_note=0. If pend_rest==0, then next cycle: state=PLAY, audio_out=1, cnt=table[pend_idx]-1, cur_note=pend_idx.
  - PLAY: if cnt!=0, cnt decrements. If cnt==0 (terminal):
    - pend_rest==1 → audio_out=0, state=IDLE, cur_note=0.
    - otherwise → audio_out toggles, cnt=table[pend_idx]-1, cur_note=pend_idx.
- Note changes between terminal counts are not applied until the next terminal count. Only the value present at the terminal count matters.
- Counter is unsigned CNT_W bits and never wraps. Reload values are always ≥ 4778.
- All outputs reset to 0; state=IDLE; cnt=0; note_q=0.

## Timing
- Note onset latency: note_in valid at edge N → note_q at N+1 → audio_out=1, playing=1 at N+2.
- Each half-period lasts exactly table[idx] cycles. Full period = 2·table[idx] (A4: 11364 cycles ≈ 440.0 Hz).
- Note change: the new half-period starts at the first terminal count ≥1 cycle after note_q updates.
- Rest: audio_out drops to 0 at the next terminal count, whatever its current level. It is never cut mid-half-period.
- play_en deassert behaves as a rest with the same latency. Reasserting it restarts from IDLE rules.
- Reset asserted mid-note: outputs clear immediately (asynchronous) and stay 0 until 2 cycles after deassertion plus a non-rest input.
- Simultaneous terminal count and note change in the same cycle: the value of note_q in that cycle is used.

## Configuration
- TONE_OCTAVE_EN defined: adds the octave_up port. Reload value = table[idx] >> 1 when octave_up=1, sampled at each load/terminal count (range C5..C6).
- TONE_OCTAVE_EN undefined: no octave_up port; reload is always table[idx].

## Test plan
- Reset then note_in=8'h20, play_en=1 → audio_out rises 2 cycles later. Then high 5682 cycles, low 5682, repeating. playing=1, cur_note=5.
- note_in=8'h01 changed to 8'h80 mid half-period → the current 9555-cycle half completes, then half-periods are 4778. No shorter pulse appears.
- Playing G4 (8'h10), set note_in=0 → audio_out goes 0 exactly at the next terminal count. playing=0 and cur_note=0 the same cycle, state IDLE.
- note_in=8'hA4 → cur_note=2 and half-period 7584 (priority to lowest bit). play_en=0 mid-note → rest behaviour as above.
- resetn pulsed low for 3 cycles mid-note → audio_out, playing and cur_note are 0 in the same cycle, with no clock edge required. Tone restarts 2 cycles after release.
- With TONE_OCTAVE_EN, note_in=8'h20, octave_up=1 → half-period 2841 cycles. Toggle octave_up=0 → 5682 from the next terminal count.
